instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_queue.sv | 81 ++++++++
 tb/tb_instr_fetch_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: default depth, the NOP
// word substituted for misaligned fetches, and the buffered entry layout.
package fetch_pkg;

  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries. Holds storage, head/tail pointers and the
// occupancy count; clear empties it and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic          push_misalign,
  input  logic          pop,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_instr,
  output logic          head_misalign,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  entry_t        head_entry;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_pop;

  // Popping an empty queue is ignored; a full queue is never pushed because
  // the issuer only spends credit it has.
  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push)   tail_ptr <= tail_ptr + 1'b1;
      if (do_pop) head_ptr <= head_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are never observed
  // unless count says the slot is occupied, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_ptr] <= '{pc: push_pc, instr: push_instr, misalign: push_misalign};
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    head_entry = '0;
    if (count != '0) head_entry = mem[head_ptr];
  end

  assign head_pc       = head_entry.pc;
  assign head_instr    = head_entry.instr;
  assign head_misalign = head_entry.misalign;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues memory reads against queue credit, tracks
// the single in-flight read, and handles redirects before entries reach decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          armed;
  logic          req_valid;
  logic [31:0]   req_pc;
  logic          req_misalign;
  logic [CW-1:0] count;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   push_instr;

  // Credit counts the registered occupancy plus the outstanding read, so a
  // pop in the current cycle does not make room until the next one.
  assign issue     = armed && pc_valid && !flush && ((count + CW'(req_valid)) < DEPTH_C);
  assign imem_en   = issue;
  assign pc_ready  = issue;
  assign imem_addr = {pc_addr[31:2], 2'b00};

  assign push       = req_valid && !flush;
  assign pop        = if_valid && if_ready && !flush;
  assign push_instr = req_misalign ? NOP_INSTR : imem_rdata;
  assign if_valid   = (count != '0);

  // armed holds off issue until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed        <= 1'b0;
      req_valid    <= 1'b0;
      req_pc       <= '0;
      req_misalign <= 1'b0;
    end else begin
      armed     <= 1'b1;
      req_valid <= issue;
      if (issue) begin
        req_pc       <= pc_addr;
        req_misalign <= |pc_addr[1:0];
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .clear         (flush),
    .push          (push),
    .push_pc       (req_pc),
    .push_instr    (push_instr),
    .push_misalign (req_misalign),
    .pop           (pop),
    .head_pc       (if_pc),
    .head_instr    (if_instr),
    .head_misalign (if_misalign),
    .count         (count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a random
// run compared against a queue-level model of the fetch behaviour.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_misalign (if_misalign)
  );

  // Instruction memory: the word read is the aligned address XOR 0xFFFF0000.
  logic [31:0] mem_addr_q = '0;
  always @(posedge clk) if (imem_en) mem_addr_q <= imem_addr;
  assign imem_rdata = mem_addr_q ^ 32'hFFFF_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hFFFF_0000;
  endfunction

  function automatic entry_t make_entry(input logic [31:0] a);
    entry_t e;
    e.pc       = a;
    e.misalign = (a[1:0] != 2'b00);
    e.instr    = e.misalign ? 32'h0 : mem_word(a);
    return e;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic drive(input logic v, input logic [31:0] a, input logic fl, input logic rdy);
    @(negedge clk);
    pc_valid = v;
    pc_addr  = a;
    flush    = fl;
    if_ready = rdy;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_valid = 1'b1; pc_addr = 32'h1000; flush = 1'b0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({if_valid, if_pc, if_instr, if_misalign, imem_en, pc_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b pc=%h instr=%h mis=%0b en=%0b rdy=%0b want all 0",
               if_valid, if_pc, if_instr, if_misalign, imem_en, pc_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (imem_en !== 1'b0) begin
      bad++; $display("FAIL reset_release_no_issue: imem_en=%0b want 0", imem_en);
    end
    @(negedge clk);
    #1;
    total++;
    if ({imem_en, pc_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_first_issue: en=%0b rdy=%0b want 1 1", imem_en, pc_ready);
    end
    pc_valid = 1'b0;

    // Three entries queued, then reset dropped in the middle of a cycle.
    drive(1'b1, 32'h3000, 1'b0, 1'b0);
    drive(1'b1, 32'h3004, 1'b0, 1'b0);
    drive(1'b1, 32'h3008, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if ({if_valid, if_pc} !== {1'b1, 32'h3000}) begin
      bad++; $display("FAIL reset_prefill_head: got v=%0b pc=%h want 1 00003000", if_valid, if_pc);
    end
    pc_valid = 1'b1;
    pc_addr  = 32'h300C;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({if_valid, if_pc, if_instr, if_misalign, imem_en, pc_ready} !== '0) begin
      bad++;
      $display("FAIL reset_midstream: got v=%0b pc=%h instr=%h mis=%0b en=%0b rdy=%0b want all 0",
               if_valid, if_pc, if_instr, if_misalign, imem_en, pc_ready);
    end
    @(negedge clk);
    reset    = 1'b1;
    pc_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({if_valid, if_pc} !== '0) begin
        bad++; $display("FAIL reset_after_release: got v=%0b pc=%h want empty", if_valid, if_pc);
      end
    end
    drain();
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
      total++;
      if (pc_ready !== (i < 3)) begin
        bad++; $display("FAIL stream_ready[%0d]: got %0b want %0b", i, pc_ready, i < 3);
      end
      total++;
      if (i >= 2 && i <= 4) begin
        exp_pc = 32'h1000 + 32'(4 * (i - 2));
        if ({if_valid, if_pc, if_instr, if_misalign} !== {1'b1, exp_pc, mem_word(exp_pc), 1'b0}) begin
          bad++;
          $display("FAIL stream_head[%0d]: got v=%0b pc=%h instr=%h want 1 %h %h",
                   i, if_valid, if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
      end else if ({if_valid, if_pc, if_instr} !== '0) begin
        bad++; $display("FAIL stream_empty[%0d]: got v=%0b pc=%h want empty", i, if_valid, if_pc);
      end
    end
    drain();
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h1002, 1'b0, 1'b1);
    total++;
    if ({imem_en, imem_addr} !== {1'b1, 32'h1000}) begin
      bad++; $display("FAIL misalign_addr: got en=%0b addr=%h want 1 00001000", imem_en, imem_addr);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({if_valid, if_pc, if_instr, if_misalign} !== {1'b1, 32'h1002, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL misalign_entry: got v=%0b pc=%h instr=%h mis=%0b want 1 00001002 00000000 1",
               if_valid, if_pc, if_instr, if_misalign);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * ((i < 4) ? i : 4)), 1'b0, 1'b0);
      total++;
      if (pc_ready !== (i < 4)) begin
        bad++; $display("FAIL bp_ready[%0d]: got %0b want %0b", i, pc_ready, i < 4);
      end
      if (i >= 2) begin
        total++;
        if ({if_valid, if_pc} !== {1'b1, 32'h1000}) begin
          bad++; $display("FAIL bp_head[%0d]: got v=%0b pc=%h want 1 00001000", i, if_valid, if_pc);
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      drive(j == 0, 32'h1010, 1'b0, 1'b1);
      if (j == 0) begin
        total++;
        if (pc_ready !== 1'b0) begin
          bad++; $display("FAIL bp_pop_no_credit: got %0b want 0", pc_ready);
        end
      end
      total++;
      if (j < 4) begin
        exp_pc = 32'h1000 + 32'(4 * j);
        if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          bad++;
          $display("FAIL bp_drain[%0d]: got v=%0b pc=%h instr=%h want 1 %h %h",
                   j, if_valid, if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
      end else if (if_valid !== 1'b0) begin
        bad++; $display("FAIL bp_drained: if_valid=%0b want 0", if_valid);
      end
    end
    drive(1'b1, 32'h1010, 1'b0, 1'b1);
    total++;
    if (pc_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_back: got %0b want 1", pc_ready);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h2000, 1'b0, 1'b1);
    total++;
    if (pc_ready !== 1'b1) begin
      bad++; $display("FAIL flush_accept: got %0b want 1", pc_ready);
    end
    drive(1'b1, 32'h2004, 1'b1, 1'b1);
    total++;
    if ({pc_ready, imem_en} !== 2'b00) begin
      bad++; $display("FAIL flush_no_issue: rdy=%0b en=%0b want 0 0", pc_ready, imem_en);
    end
    drive(1'b1, 32'h0800, 1'b0, 1'b1);
    total++;
    if ({if_valid, pc_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_after: v=%0b rdy=%0b want 0 1", if_valid, pc_ready);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL flush_discard: v=%0b pc=%h want 0", if_valid, if_pc);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0800, 32'hFFFF_0800}) begin
      bad++; $display("FAIL flush_next: got v=%0b pc=%h instr=%h want 1 00000800 ffff0800", if_valid, if_pc, if_instr);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL flush_empty: v=%0b want 0", if_valid);
    end
    drain();
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    // count=3 with one read outstanding: push and pop land together.
    drive(1'b1, 32'h4010, 1'b0, 1'b1);
    total++;
    if ({pc_ready, if_valid, if_pc} !== {1'b0, 1'b1, 32'h4000}) begin
      bad++; $display("FAIL pp_same_cycle: rdy=%0b v=%0b pc=%h want 0 1 00004000", pc_ready, if_valid, if_pc);
    end
    drive(1'b1, 32'h4010, 1'b0, 1'b0);
    total++;
    if ({pc_ready, if_pc} !== {1'b1, 32'h4004}) begin
      bad++; $display("FAIL pp_count_le3: rdy=%0b pc=%h want 1 00004004", pc_ready, if_pc);
    end
    drive(1'b1, 32'h4014, 1'b0, 1'b0);
    total++;
    if (pc_ready !== 1'b0) begin
      bad++; $display("FAIL pp_count_ge3: rdy=%0b want 0", pc_ready);
    end
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (j < 4) begin
        exp_pc = 32'h4004 + 32'(4 * j);
        if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          bad++; $display("FAIL pp_order[%0d]: got v=%0b pc=%h want 1 %h", j, if_valid, if_pc, exp_pc);
        end
      end else if (if_valid !== 1'b0) begin
        bad++; $display("FAIL pp_empty: v=%0b want 0", if_valid);
      end
    end
    drain();
  endtask

  task automatic test_random();
    entry_t      m_q[$];
    entry_t      m_pend[$];
    entry_t      exp_e;
    logic        v, fl, rdy, exp_ready;
    logic [31:0] a;
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(9) < 7);
      a   = $urandom & 32'h0000_FFFF;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      fl  = ($urandom_range(19) == 0);
      rdy = ($urandom_range(9) < 6);
      drive(v, a, fl, rdy);
      exp_ready = v && !fl && ((m_q.size() + m_pend.size()) < DEPTH);
      total++;
      if ({pc_ready, imem_en} !== {exp_ready, exp_ready}) begin
        bad++; $display("FAIL rand_ready[%0d]: rdy=%0b en=%0b want %0b", n, pc_ready, imem_en, exp_ready);
      end
      if (exp_ready) begin
        total++;
        if (imem_addr !== {a[31:2], 2'b00}) begin
          bad++; $display("FAIL rand_addr[%0d]: got %h want %h", n, imem_addr, {a[31:2], 2'b00});
        end
      end
      exp_e = (m_q.size() != 0) ? m_q[0] : '0;
      total++;
      if ({if_valid, if_pc, if_instr, if_misalign} !== {m_q.size() != 0, exp_e.pc, exp_e.instr, exp_e.misalign}) begin
        bad++;
        $display("FAIL rand_head[%0d]: got v=%0b pc=%h instr=%h mis=%0b want %0b %h %h %0b",
                 n, if_valid, if_pc, if_instr, if_misalign, m_q.size() != 0, exp_e.pc, exp_e.instr, exp_e.misalign);
      end
      if (fl) begin
        m_q.delete();
        m_pend.delete();
      end else begin
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
        if (exp_ready) m_pend.push_back(make_entry(a));
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_misalign();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
